// File: rtl/alu_acc_sequencer.sv
// Microcoded sequencer driving the ALU/accumulator: fetch+exec is 2 cycles per instruction.
// ALU_EXT stalls in WAIT with ext_ready high until ext_valid; rst overrides everything.
module alu_acc_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_WIDTH   = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            start_addr,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH-1:0]            prog_addr,
    input  logic [4+OP_WIDTH+DATA_WIDTH-1:0] prog_data,
    input  logic [DATA_WIDTH-1:0]            ext_data,
    input  logic                             ext_valid,
    output logic                             ext_ready,
    output logic                             dp_ce,
    output logic [OP_WIDTH-1:0]              dp_op,
    output logic [DATA_WIDTH-1:0]            dp_in,
    input  logic                             dp_zero
);
    localparam int IW = 4 + OP_WIDTH + DATA_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [3:0] K_ALU_IMM = 4'd1;
    localparam logic [3:0] K_ALU_EXT = 4'd2;
    localparam logic [3:0] K_JMP     = 4'd3;
    localparam logic [3:0] K_JZ      = 4'd4;
    localparam logic [3:0] K_JNZ     = 4'd5;
    localparam logic [3:0] K_HALT    = 4'd6;

    logic [2:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt, pc_inc, target;
    logic [OP_WIDTH-1:0]   op_lat, op_lat_nxt;
    logic [3:0]            kind;
    logic [OP_WIDTH-1:0]   opf;
    logic [DATA_WIDTH-1:0] imm;
    logic                  ce_c, ready_c;
    logic [OP_WIDTH-1:0]   op_c;
    logic [DATA_WIDTH-1:0] in_c;

    assign kind   = prog_data[IW-1 -: 4];
    assign opf    = prog_data[IW-5 -: OP_WIDTH];
    assign imm    = prog_data[DATA_WIDTH-1:0];
    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign target = imm[ADDR_WIDTH-1:0];

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        op_lat_nxt = op_lat;
        ce_c       = 1'b0;
        ready_c    = 1'b0;
        op_c       = '0;
        in_c       = '0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_nxt    = start_addr;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
                case (kind)
                    K_ALU_IMM: begin
                        ce_c = 1'b1;
                        op_c = opf;
                        in_c = imm;
                    end
                    K_ALU_EXT: begin
                        op_lat_nxt = opf;
                        pc_nxt     = pc;
                        state_nxt  = S_WAIT;
                    end
                    K_JMP:   pc_nxt = target;
                    K_JZ:    if (dp_zero)  pc_nxt = target;
                    K_JNZ:   if (!dp_zero) pc_nxt = target;
                    K_HALT: begin
                        pc_nxt    = pc;
                        state_nxt = S_HALTED;
                    end
                    default: ; // NOP and unused kinds just advance
                endcase
            end
            S_WAIT: begin
                ready_c = 1'b1;
                if (ext_valid) begin
                    ce_c      = 1'b1;
                    op_c      = op_lat;
                    in_c      = ext_data;
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            op_lat <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            op_lat <= op_lat_nxt;
        end
    end

    // Datapath strobes are suppressed in the reset cycle so nothing is written while rst is high.
    assign prog_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
    assign done      = (state == S_HALTED);
    assign ext_ready = ready_c & ~rst;
    assign dp_ce     = ce_c & ~rst;
    assign dp_op     = rst ? '0 : op_c;
    assign dp_in     = rst ? '0 : in_c;

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Microcoded sequencer for the 16-bit ALU + accumulator datapath.
- Fetches instruction words from a synchronous program memory and drives the datapath `op`, `in` and `ce` inputs.
- Branches on the accumulator `zero` flag.
- Can stall on an external operand handshake.
- Sits between the program ROM / host and the ALU/accumulator pair; the datapath needs no other control source.

Parameters:
- DATA_WIDTH, 16, datapath operand / accumulator width.
- OP_WIDTH, 8, ALU opcode width (passed through unmodified).
- ADDR_WIDTH, 8, program address width.
- Derived, not a parameter: IW = 4+OP_WIDTH+DATA_WIDTH, the instruction width (28 by default).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at start_addr.
- start_addr  in  ADDR_WIDTH  entry address, sampled with start.
- busy  out  1  high in FETCH/EXEC/WAIT.
- done  out  1  high in HALTED.
- prog_addr  out  ADDR_WIDTH  program memory address (registered PC).
- prog_data  in  IW  instruction word, valid one cycle after prog_addr.
- ext_data  in  DATA_WIDTH  external operand.
- ext_valid  in  1  external operand valid.
- ext_ready  out  1  external operand accepted this cycle.
- dp_ce  out  1  accumulator clock enable.
- dp_op  out  OP_WIDTH  ALU opcode.
- dp_in  out  DATA_WIDTH  ALU second operand.
- dp_zero  in  1  accumulator zero flag.

Behaviour:
- Instruction fields:
  - kind = prog_data[IW-1:IW-4]
  - opf = prog_data[IW-5:DATA_WIDTH]
  - imm = prog_data[DATA_WIDTH-1:0]
- Instruction kinds:
  - 0 NOP
  - 1 ALU_IMM
  - 2 ALU_EXT
  - 3 JMP
  - 4 JZ
  - 5 JNZ
  - 6 HALT
  - 7..15 are treated as NOP.
- States are IDLE, FETCH, EXEC, WAIT, HALTED. Reset enters IDLE.
- Reset values:
  - pc=0, so prog_addr=0.
  - busy=0, done=0, ext_ready=0, dp_ce=0, dp_op=0, dp_in=0.
- IDLE:
  - start=1 -> pc<=start_addr, go FETCH.
  - Otherwise stay in IDLE.
- FETCH: prog_addr=pc is presented; next state is EXEC. Memory latency is exactly 1 cycle.
- EXEC (prog_data valid), per kind:
  - NOP: pc<=pc+1, go FETCH.
  - ALU_IMM: dp_op=opf, dp_in=imm, dp_ce=1 for this single cycle; pc<=pc+1; go FETCH.
  - ALU_EXT: latch opf into an internal register; go WAIT. dp_ce=0 in this cycle.
  - JMP: pc<=imm[ADDR_WIDTH-1:0]; go FETCH.
  - JZ: dp_zero=1 -> pc<=imm[ADDR_WIDTH-1:0]; else pc<=pc+1. Go FETCH.
  - JNZ: dp_zero=0 -> branch to imm[ADDR_WIDTH-1:0]; else pc<=pc+1. Go FETCH.
  - HALT: go HALTED; pc unchanged.
- WAIT:
  - ext_ready=1 in every cycle of WAIT.
  - When ext_valid=1: dp_op=latched opf, dp_in=ext_data, dp_ce=1 for that one cycle; pc<=pc+1; go FETCH.
  - When ext_valid=0: stay in WAIT with dp_ce=0.
- HALTED:
  - done=1.
  - start=1 -> done clears next cycle, pc<=start_addr, go FETCH.
- Output gating:
  - dp_ce is asserted only in the single ALU-executing cycle.
  - dp_op and dp_in are 0 whenever dp_ce=0. They are combinational from state and prog_data/ext_data, so the ALU result is valid in the same cycle that ce captures it.
- Zero flag timing: dp_zero reflects the accumulator after the previous write. Since every instruction is at least 2 cycles, JZ/JNZ always see the result of the preceding ALU instruction.
- Cycle counts: NOP, ALU_IMM, JMP, JZ and JNZ take 2 cycles each. ALU_EXT takes 3 cycles plus the number of ext_valid=0 cycles spent in WAIT.
- PC arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH (e.g. 0xFF -> 0x00). Branch targets are truncated to ADDR_WIDTH bits.
- start is ignored in FETCH, EXEC and WAIT.
- rst has priority over everything, including mid-WAIT and a simultaneous start. The next cycle shows IDLE with all outputs at their reset values, and no dp_ce is issued in the reset cycle.

Test Plan:
- Reset, start pulse with start_addr=0x10, ROM[0x10]=ALU_IMM op=0x03 imm=0x1234:
  - prog_addr=0x10 in FETCH.
  - Next cycle dp_ce=1, dp_op=0x03, dp_in=0x1234.
  - prog_addr=0x11 after that.
  - busy=1 throughout.
- Branch: ROM holds ALU_IMM then JZ to 0x40.
  - Bench ALU drives dp_zero=1 -> next fetch at 0x40.
  - Repeat with dp_zero=0 -> next fetch at pc+1.
  - JNZ gives the mirrored results.
- ALU_EXT with ext_valid held low for 5 cycles, then ext_data=0xBEEF, ext_valid=1:
  - ext_ready=1 for all 6 WAIT cycles.
  - dp_ce=1 only in the 6th cycle, with dp_in=0xBEEF.
  - Total instruction time is 8 cycles.
- Wrap and halt: start_addr=0xFF with ROM[0xFF]=NOP and ROM[0x00]=HALT.
  - Fetch sequence is 0xFF then 0x00.
  - done=1, busy=0.
  - Further start pulses while in HALTED restart execution.
- Reset mid-WAIT with ext_valid=1 and start asserted in the same cycle:
  - No dp_ce pulse.
  - Next cycle IDLE, prog_addr=0, done=0, busy=0.
- Illegal kind 0xA plus start pulses during busy:
  - Kind 0xA behaves as NOP (pc+1, dp_ce=0).
  - start pulses while busy leave pc and state unaffected.
